// File: rtl/scan_mux_nto1.sv
// scan_mux_nto1: N-channel registered multiplexer with a valid/ready output.
// Manual mode picks the channel named by sel; scan mode walks round-robin over
// the channels enabled in en_mask, optionally idling 'dwell' cycles between an
// accepted sample and the next one. One sample slot; it is held under back-pressure.
module scan_mux_nto1 #(
  parameter  int N_CH    = 8,
  parameter  int DW      = 8,
  parameter  int DWELL_W = 8,
  localparam int SW      = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   din,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [N_CH-1:0]      en_mask,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [SW-1:0]        out_ch
);

  // IDLE: slot empty; VALID: sample pending; WAIT: dwell gap after an accept.
  typedef enum logic [1:0] {
    S_IDLE,
    S_VALID,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      data_q, data_d;
  logic [SW-1:0]      ch_q, ch_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0]      ch_data [N_CH];

  logic [DW-1:0]      man_data;
  logic               scan_found;
  logic [SW-1:0]      scan_ch;
  logic [SW-1:0]      scan_ptr_next;
  logic               issue;

  // Split the packed input bus into one word per channel.
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_data[k] = din[k*DW +: DW];
  end

  // Manual selection; a select beyond the last channel yields zero data.
  always_comb begin
    man_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SW'(k)) man_data = ch_data[SW'(k)];
    end
  end

  // Round-robin search: first enabled channel at or after ptr, wrapping at N_CH.
  always_comb begin
    int idx;
    idx        = 0;
    scan_found = 1'b0;
    scan_ch    = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!scan_found && en_mask[SW'(idx)]) begin
        scan_found = 1'b1;
        scan_ch    = SW'(idx);
      end
    end
    scan_ptr_next = (scan_ch == SW'(N_CH - 1)) ? '0 : scan_ch + SW'(1);
  end

  // Next-state logic: decide whether this edge is an issue point, then issue
  // according to the mode seen at this edge.
  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;

    unique case (state_q)
      S_IDLE: issue = 1'b1;
      S_VALID: begin
        if (out_ready) begin
          if (!mode || dwell == '0) begin
            issue = 1'b1;
          end else begin
            cnt_d   = dwell;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // WAIT is only entered from scan mode, so mode=0 here means the
        // scan was abandoned: serve the manual select right away.
        if (!mode || cnt_q == DWELL_W'(1)) begin
          issue = 1'b1;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      cnt_d = '0;
      if (!mode) begin
        data_d  = man_data;
        ch_d    = sel;
        state_d = S_VALID;
      end else if (scan_found) begin
        data_d  = ch_data[scan_ch];
        ch_d    = scan_ch;
        ptr_d   = scan_ptr_next;
        state_d = S_VALID;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and datapath registers; reset empties the slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_VALID);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_scan_mux_nto1.sv
// Directed bench for scan_mux_nto1: an 8-channel instance exercises reset,
// manual, stall, scan and dwell behaviour; a 5-channel instance covers
// out-of-range manual selects.
module tb_scan_mux_nto1;

  logic        clk;
  logic        rst_n;

  logic [63:0] din;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  en_mask;
  logic [7:0]  dwell;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;

  logic [39:0] din5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [4:0]  en_mask5;
  logic [7:0]  dwell5;
  logic        ready5;
  logic        out_valid5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;

  int n_checks = 0;
  int n_errors = 0;

  scan_mux_nto1 #(.N_CH(8), .DW(8), .DWELL_W(8)) u8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .mode      (mode),
    .sel       (sel),
    .en_mask   (en_mask),
    .dwell     (dwell),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  scan_mux_nto1 #(.N_CH(5), .DW(8), .DWELL_W(8)) u5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din5),
    .mode      (mode5),
    .sel       (sel5),
    .en_mask   (en_mask5),
    .dwell     (dwell5),
    .out_ready (ready5),
    .out_valid (out_valid5),
    .out_data  (out_data5),
    .out_ch    (out_ch5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sample(input string tag, input logic v, input logic [2:0] ch,
                              input logic [7:0] d);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_ch"},    32'(out_ch),    32'(ch));
    check({tag, "_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'(16 + k);
    for (int k = 0; k < 5; k++) din5[k*8 +: 8] = 8'(16 + k);
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 3'd0;
    en_mask   = 8'h00;
    dwell     = 8'd0;
    out_ready = 1'b0;
    mode5     = 1'b0;
    sel5      = 3'd6;
    en_mask5  = 5'h1f;
    dwell5    = 8'd0;
    ready5    = 1'b1;

    #2;
    check_sample("reset_init", 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual sweep: each select appears one edge later, back-to-back.
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      check_sample($sformatf("sweep%0d", s), 1'b1, 3'(s), 8'(16 + s));
    end

    // Stall: sample ch3 held while sel and din[3] move.
    sel = 3'd3;
    tick();
    check_sample("stall_issue", 1'b1, 3'd3, 8'h13);
    out_ready = 1'b0;
    sel = 3'd6;
    din[3*8 +: 8] = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_sample($sformatf("stall_hold%0d", i), 1'b1, 3'd3, 8'h13);
    end
    out_ready = 1'b1;
    tick();
    check_sample("stall_release", 1'b1, 3'd6, 8'h16);
    din[3*8 +: 8] = 8'h13;

    // Asynchronous reset while a sample is pending.
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_sample("reset_mid_valid", 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan over mask 1001_0101 with no dwell: 0,2,4,7,0,2.
    mode      = 1'b1;
    en_mask   = 8'b1001_0101;
    dwell     = 8'd0;
    out_ready = 1'b1;
    begin
      logic [2:0] seq [6];
      seq = '{3'd0, 3'd2, 3'd4, 3'd7, 3'd0, 3'd2};
      for (int i = 0; i < 6; i++) begin
        tick();
        check_sample($sformatf("scan%0d", i), 1'b1, seq[i], 8'(16 + int'(seq[i])));
      end
    end

    // Dwell=3 over all channels, starting from ptr=0 after a reset.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    en_mask = 8'hFF;
    dwell   = 8'd3;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_sample($sformatf("dwell_issue%0d", i), 1'b1, 3'(i % 8), 8'(16 + (i % 8)));
      if (i < 8) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          check($sformatf("dwell_gap%0d_%0d", i, g), 32'(out_valid), 32'd0);
        end
      end
    end

    // Mode 1->0 during WAIT: manual sample on the next edge, dwell abandoned.
    tick();
    check("abort_wait_valid", 32'(out_valid), 32'd0);
    mode = 1'b0;
    sel  = 3'd5;
    tick();
    check_sample("abort_manual", 1'b1, 3'd5, 8'h15);

    // Scan with an empty mask: accept empties the slot, nothing issued.
    mode    = 1'b1;
    en_mask = 8'h00;
    dwell   = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("empty_mask%0d", i), 32'(out_valid), 32'd0);
    end

    // Five-channel instance: out-of-range select gives zero data.
    check("n5_sel6_valid", 32'(out_valid5), 32'd1);
    check("n5_sel6_ch",    32'(out_ch5),    32'd6);
    check("n5_sel6_data",  32'(out_data5),  32'd0);
    sel5 = 3'd4;
    tick();
    check("n5_sel4_ch",    32'(out_ch5),    32'd4);
    check("n5_sel4_data",  32'(out_data5),  32'h14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
